// File: rtl/fnd_scan_rx.sv
// fnd_scan_rx: receive side of a multiplexed 7-segment display bus.
// Registers the bus and waits for each common enable to settle. It then decodes
// the segment pattern of that digit into a shadow frame. When all NUM_DIGIT
// digits have been captured, the shadow frame is published together with the
// min:sec values derived from it.
module fnd_scan_rx #(
    parameter int unsigned NUM_DIGIT = 6,
    parameter int unsigned SETTLE    = 4,
    parameter int unsigned TIMEOUT   = 20000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [6:0]             i_seg,
    input  logic                   i_seg_dp,
    input  logic [NUM_DIGIT-1:0]   i_seg_enb,
    output logic [4*NUM_DIGIT-1:0] o_digits,
    output logic [NUM_DIGIT-1:0]   o_dp,
    output logic [5:0]             o_sec,
    output logic [5:0]             o_min,
    output logic                   o_frame_vld,
    output logic                   o_err,
    output logic                   o_stale
);

    localparam int unsigned IDX_W = (NUM_DIGIT > 1) ? $clog2(NUM_DIGIT) : 1;
    localparam int unsigned ZC_W  = $clog2(NUM_DIGIT + 1);
    localparam int unsigned CNT_W = 8;
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned DIG_W = 4 * NUM_DIGIT;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    // Segment pattern -> {err, digit}; unknown patterns map to 4'hE with err set.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h7E:   r = {1'b0, 4'h0};
            7'h30:   r = {1'b0, 4'h1};
            7'h6D:   r = {1'b0, 4'h2};
            7'h79:   r = {1'b0, 4'h3};
            7'h33:   r = {1'b0, 4'h4};
            7'h5B:   r = {1'b0, 4'h5};
            7'h5F:   r = {1'b0, 4'h6};
            7'h70:   r = {1'b0, 4'h7};
            7'h7F:   r = {1'b0, 4'h8};
            7'h73:   r = {1'b0, 4'h9};
            7'h00:   r = {1'b0, 4'hF};
            default: r = {1'b1, 4'hE};
        endcase
        return r;
    endfunction

    // Two decimal digits -> 6-bit value; non-decimal digits or results above 63 give 6'h3F.
    function automatic logic [5:0] pair_value(input logic [3:0] tens, input logic [3:0] units);
        logic [6:0] v;
        logic [5:0] r;
        v = 7'(tens) * 7'd10 + 7'(units);
        if ((tens > 4'd9) || (units > 4'd9) || (v > 7'd63)) begin
            r = 6'h3F;
        end else begin
            r = v[5:0];
        end
        return r;
    endfunction

    // Input stage
    logic [6:0]           seg_q;
    logic                 dp_q;
    logic [NUM_DIGIT-1:0] enb_q;

    // Control state
    state_t               state_q, state_d;
    logic [IDX_W-1:0]     k_q, k_d;
    logic [CNT_W-1:0]     scnt_q, scnt_d;
    logic [NUM_DIGIT-1:0] mask_q, mask_d;
    logic                 ill_prev_q, ill_prev_d;
    logic [TO_W-1:0]      to_cnt_q, to_cnt_d;

    // Shadow frame being assembled
    logic [DIG_W-1:0]     shd_dig_q, shd_dig_d;
    logic [NUM_DIGIT-1:0] shd_dp_q, shd_dp_d;

    // Registered outputs
    logic [DIG_W-1:0]     digits_q, digits_d;
    logic [NUM_DIGIT-1:0] odp_q, odp_d;
    logic [5:0]           sec_q, sec_d;
    logic [5:0]           min_q, min_d;
    logic                 vld_q, vld_d;
    logic                 err_q, err_d;
    logic                 stale_q, stale_d;

    // Enable classification
    logic [ZC_W-1:0]      zero_cnt;
    logic [IDX_W-1:0]     zero_idx;
    logic                 is_none;
    logic                 is_one;
    logic                 is_illegal;

    logic [4:0]           dec;
    logic                 capture;

    // Register the raw bus before any use.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q <= '0;
            dp_q  <= 1'b0;
            enb_q <= '1;
        end else begin
            seg_q <= i_seg;
            dp_q  <= i_seg_dp;
            enb_q <= i_seg_enb;
        end
    end

    // Count the active-low enables and remember the index of the active one.
    always_comb begin
        zero_cnt = '0;
        zero_idx = '0;
        for (int i = 0; i < NUM_DIGIT; i++) begin
            if (!enb_q[i]) begin
                zero_cnt = zero_cnt + ZC_W'(1);
                zero_idx = IDX_W'(i);
            end
        end
        is_none    = (zero_cnt == ZC_W'(0));
        is_one     = (zero_cnt == ZC_W'(1));
        is_illegal = !is_none && !is_one;
    end

    assign dec = seg_decode(seg_q);

    // Next-state, capture, frame completion and timeout logic.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        scnt_d     = scnt_q;
        mask_d     = mask_q;
        shd_dig_d  = shd_dig_q;
        shd_dp_d   = shd_dp_q;
        digits_d   = digits_q;
        odp_d      = odp_q;
        sec_d      = sec_q;
        min_d      = min_q;
        vld_d      = 1'b0;
        capture    = 1'b0;
        ill_prev_d = is_illegal;
        to_cnt_d   = (to_cnt_q == TO_W'(TIMEOUT)) ? to_cnt_q : to_cnt_q + TO_W'(1);

        if (is_illegal) begin
            state_d = ST_IDLE;
            mask_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (is_one) begin
                        state_d = ST_SETTLE;
                        k_d     = zero_idx;
                        scnt_d  = '0;
                    end
                end
                ST_SETTLE: begin
                    if (is_none) begin
                        state_d = ST_IDLE;
                    end else if (zero_idx != k_q) begin
                        k_d    = zero_idx;
                        scnt_d = '0;
                    end else if (scnt_q == CNT_W'(SETTLE - 1)) begin
                        state_d = ST_CAPTURE;
                    end else begin
                        scnt_d = scnt_q + CNT_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    capture = 1'b1;
                    state_d = ST_HOLD;
                end
                ST_HOLD: begin
                    if (is_none) begin
                        state_d = ST_IDLE;
                    end else if (zero_idx != k_q) begin
                        state_d = ST_SETTLE;
                        k_d     = zero_idx;
                        scnt_d  = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (capture) begin
            shd_dig_d[{k_q, 2'b00} +: 4] = dec[3:0];
            shd_dp_d[k_q]                = dp_q;
            mask_d[k_q]                  = 1'b1;
            // Publish in the same edge so o_frame_vld follows the last capture by one cycle.
            if (&mask_d) begin
                digits_d = shd_dig_d;
                odp_d    = shd_dp_d;
                sec_d    = pair_value(shd_dig_d[7:4], shd_dig_d[3:0]);
                min_d    = pair_value(shd_dig_d[15:12], shd_dig_d[11:8]);
                vld_d    = 1'b1;
                mask_d   = '0;
                to_cnt_d = '0;
            end
        end

        err_d   = (is_illegal && !ill_prev_q) || (capture && dec[4]);
        stale_d = (to_cnt_d == TO_W'(TIMEOUT));
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            scnt_q     <= '0;
            mask_q     <= '0;
            ill_prev_q <= 1'b0;
            to_cnt_q   <= '0;
            shd_dig_q  <= '1;
            shd_dp_q   <= '0;
            digits_q   <= '1;
            odp_q      <= '0;
            sec_q      <= 6'h3F;
            min_q      <= 6'h3F;
            vld_q      <= 1'b0;
            err_q      <= 1'b0;
            stale_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            scnt_q     <= scnt_d;
            mask_q     <= mask_d;
            ill_prev_q <= ill_prev_d;
            to_cnt_q   <= to_cnt_d;
            shd_dig_q  <= shd_dig_d;
            shd_dp_q   <= shd_dp_d;
            digits_q   <= digits_d;
            odp_q      <= odp_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            vld_q      <= vld_d;
            err_q      <= err_d;
            stale_q    <= stale_d;
        end
    end

    assign o_digits    = digits_q;
    assign o_dp        = odp_q;
    assign o_sec       = sec_q;
    assign o_min       = min_q;
    assign o_frame_vld = vld_q;
    assign o_err       = err_q;
    assign o_stale     = stale_q;

endmodule

// File: tb/tb_fnd_scan_rx.sv
// Testbench for fnd_scan_rx: directed scans of the display bus, with a scoreboard of expected frames.
module tb_fnd_scan_rx;

    localparam int unsigned ND  = 6;
    localparam int unsigned TMO = 300;

    typedef struct packed {
        logic [23:0] dig;
        logic [5:0]  dp;
        logic [5:0]  sec;
        logic [5:0]  min;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  i_seg;
    logic        i_seg_dp;
    logic [5:0]  i_seg_enb;
    logic [23:0] o_digits;
    logic [5:0]  o_dp;
    logic [5:0]  o_sec;
    logic [5:0]  o_min;
    logic        o_frame_vld;
    logic        o_err;
    logic        o_stale;

    int   vectors = 0;
    int   misses  = 0;
    int   frames_seen = 0;
    int   errs_seen   = 0;
    exp_t exp_q[$];

    fnd_scan_rx #(.NUM_DIGIT(ND), .SETTLE(4), .TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_seg       (i_seg),
        .i_seg_dp    (i_seg_dp),
        .i_seg_enb   (i_seg_enb),
        .o_digits    (o_digits),
        .o_dp        (o_dp),
        .o_sec       (o_sec),
        .o_min       (o_min),
        .o_frame_vld (o_frame_vld),
        .o_err       (o_err),
        .o_stale     (o_stale)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            misses++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'h7E;  4'h1: s = 7'h30;  4'h2: s = 7'h6D;  4'h3: s = 7'h79;
            4'h4: s = 7'h33;  4'h5: s = 7'h5B;  4'h6: s = 7'h5F;  4'h7: s = 7'h70;
            4'h8: s = 7'h7F;  4'h9: s = 7'h73;  default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Drive one digit slot for dwell cycles (inputs change on the falling edge).
    task automatic scan(input int k, input logic [6:0] seg, input logic dp, input int dwell);
        logic [5:0] e;
        e = 6'h3F;
        e[k] = 1'b0;
        i_seg_enb = e;
        i_seg     = seg;
        i_seg_dp  = dp;
        repeat (dwell) @(negedge clk);
    endtask

    task automatic scan_range(input logic [23:0] dig, input logic [5:0] dp,
                              input int first, input int last, input int dwell);
        for (int k = first; k <= last; k++) scan(k, enc(dig[4*k +: 4]), dp[k], dwell);
    endtask

    task automatic idle(input int n);
        i_seg_enb = 6'h3F;
        i_seg     = 7'h00;
        i_seg_dp  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [23:0] dig, input logic [5:0] dp, input logic [5:0] sec,
                        input logic [5:0] min);
        exp_t e;
        e.dig = dig; e.dp = dp; e.sec = sec; e.min = min;
        exp_q.push_back(e);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_digits"}, 32'(o_digits), 32'hFFFFFF);
        chk({tag, "_dp"},     32'(o_dp), 32'h0);
        chk({tag, "_sec"},    32'(o_sec), 32'h3F);
        chk({tag, "_min"},    32'(o_min), 32'h3F);
        chk({tag, "_vld"},    32'(o_frame_vld), 32'h0);
        chk({tag, "_err"},    32'(o_err), 32'h0);
        chk({tag, "_stale"},  32'(o_stale), 32'h0);
    endtask

    // Monitor: pops an expected frame whenever the DUT publishes one.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_err) errs_seen++;
            if (o_frame_vld) begin
                exp_t e;
                frames_seen++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 32'(o_digits), 32'hDEAD_BEEF);
                end else begin
                    e = exp_q.pop_front();
                    chk("frame_digits", 32'(o_digits), 32'(e.dig));
                    chk("frame_dp",     32'(o_dp),     32'(e.dp));
                    chk("frame_sec",    32'(o_sec),    32'(e.sec));
                    chk("frame_min",    32'(o_min),    32'(e.min));
                end
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        i_seg = 7'h00; i_seg_dp = 1'b0; i_seg_enb = 6'h3F;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        idle(2);

        // 12:34 with blank upper digits and a colon dp on digit 2
        push(24'hFF1234, 6'b000100, 6'd34, 6'd12);
        scan_range(24'hFF1234, 6'b000100, 0, 5, 8);
        idle(4);
        chk("t1_frames", 32'(frames_seen), 32'd1);
        chk("t1_stale_low", 32'(o_stale), 32'd0);

        // Dwell shorter than the settle window: nothing is captured, then stale rises
        for (int r = 0; r < 3; r++) scan_range(24'hFF5678, 6'b0, 0, 5, 3);
        idle(TMO + 20);
        chk("t2_frames", 32'(frames_seen), 32'd1);
        chk("t2_stale_high", 32'(o_stale), 32'd1);

        // Illegal enable mid-frame clears the mask; six fresh captures are needed
        scan_range(24'h999999, 6'b0, 0, 2, 8);
        i_seg_enb = 6'b111100;
        repeat (2) @(negedge clk);
        idle(3);
        chk("t3_err_count", 32'(errs_seen), 32'd1);
        scan_range(24'hFF0147, 6'b000100, 3, 5, 8);
        chk("t3_no_frame", 32'(frames_seen), 32'd1);
        push(24'hFF0147, 6'b000100, 6'd47, 6'd1);
        scan_range(24'hFF0147, 6'b000100, 0, 2, 8);
        idle(4);
        chk("t3_frames", 32'(frames_seen), 32'd2);
        chk("t3_stale_cleared", 32'(o_stale), 32'd0);

        // Unknown pattern on digit 0: error pulse, digit becomes E, seconds invalid
        push(24'hFF595E, 6'b0, 6'h3F, 6'd59);
        scan(0, 7'h01, 1'b0, 8);
        scan_range(24'hFF595E, 6'b0, 1, 5, 8);
        idle(4);
        chk("t4_err_count", 32'(errs_seen), 32'd2);
        chk("t4_frames", 32'(frames_seen), 32'd3);

        // Reset after three captures; next frame needs all six digits again
        scan_range(24'h888888, 6'b0, 0, 2, 8);
        idle(1);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("t5_reset");
        rst = 1'b0;
        idle(2);
        scan_range(24'hFF2108, 6'b0, 3, 5, 8);
        chk("t5_no_frame", 32'(frames_seen), 32'd3);
        push(24'hFF2108, 6'b0, 6'd8, 6'd21);
        scan_range(24'hFF2108, 6'b0, 0, 2, 8);
        idle(4);
        chk("t5_frames", 32'(frames_seen), 32'd4);

        // Back-to-back frames 59:59 then 00:00
        push(24'hFF5959, 6'b000100, 6'd59, 6'd59);
        push(24'hFF0000, 6'b000100, 6'd0, 6'd0);
        scan_range(24'hFF5959, 6'b000100, 0, 5, 8);
        scan_range(24'hFF0000, 6'b000100, 0, 5, 8);
        idle(4);
        chk("t6_frames", 32'(frames_seen), 32'd6);

        // Range boundary: 63 is representable, 64 and 99 saturate to 3F
        push(24'hFF6363, 6'b0, 6'd63, 6'd63);
        push(24'hFF9964, 6'b0, 6'h3F, 6'h3F);
        scan_range(24'hFF6363, 6'b0, 0, 5, 8);
        scan_range(24'hFF9964, 6'b0, 0, 5, 8);
        idle(4);
        chk("t7_frames", 32'(frames_seen), 32'd8);

        chk("final_err_count", 32'(errs_seen), 32'd2);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
